inv_shift_rows_acc: RTL

INV_SHIFT_ROWS_ACC -- requirements
Module: inv_shift_rows_acc

---
 rtl/inv_shift_rows_acc_if.sv | 15 +
 rtl/inv_shift_rows_acc.sv | 65 ++++++
 2 files changed

// File: rtl/inv_shift_rows_acc_if.sv
// inv_shift_rows_acc_if: byte-in / block-out stream bundle for the InvShiftRows accumulator
interface inv_shift_rows_acc_if;
  logic [7:0]   in_byte;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [127:0] out_state;
  logic         out_valid;
  logic         out_ready;
  logic         err;
  modport master (output in_byte, in_valid, in_last, out_ready,
                  input  in_ready, out_state, out_valid, err);
  modport slave  (input  in_byte, in_valid, in_last, out_ready,
                  output in_ready, out_state, out_valid, err);
endinterface

// File: rtl/inv_shift_rows_acc.sv
// inv_shift_rows_acc: gathers 16 column-major state bytes and presents the InvShiftRows block
module inv_shift_rows_acc (
  input  logic                 clk,
  input  logic                 rst_n,
  inv_shift_rows_acc_if.slave  bus
);
  typedef enum logic {COLLECT, FULL} state_t;
  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [14:0][7:0]   mem_q, mem_d;
  logic [127:0]       out_q, out_d;
  logic               err_q, err_d;
  logic               live_q;
  logic               xfer;
  logic [15:0][7:0]   blk;
  logic [127:0]       shifted;
  // byte 15 is never stored: it goes straight into the output on the completing edge
  assign blk = {bus.in_byte, mem_q};
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign shifted[127-32*c-8*r -: 8] = blk[4*((c-r+4)%4)+r];
    end
  end
  assign bus.in_ready  = live_q && state_q == COLLECT;
  assign bus.out_valid = state_q == FULL;
  assign bus.out_state = out_q;
  assign bus.err       = err_q;
  assign xfer          = bus.in_valid && bus.in_ready;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    out_d   = out_q;
    err_d   = 1'b0;
    if (xfer) begin
      if (cnt_q != 4'd15) mem_d[cnt_q] = bus.in_byte;
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == 4'd15 && bus.in_last) begin
        state_d = FULL;
        out_d   = shifted;
      end else if (cnt_q == 4'd15 || bus.in_last) begin
        cnt_d = 4'd0;
        err_d = 1'b1;
      end
    end
    if (state_q == FULL && bus.out_ready) state_d = COLLECT;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      mem_q   <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
      out_q   <= out_d;
      err_q   <= err_d;
      live_q  <= 1'b1;
    end
  end
endmodule
